// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the instruction-fetch path and the
//   load/store path. Each access is granted in IDLE, then held for MEM_LAT
//   ACCESS cycles, then acknowledged in a single DONE cycle. When both paths
//   request at once, the grant goes to whichever path did not own the
//   previous grant. No new access starts while the core is halted.
//
// Parameters
//   MEM_LAT       memory access latency in cycles (>= 1)
//   CNT_W         width of the contention counter
//
// Ports
//   clk           clock, rising edge
//   rst_b         asynchronous reset, active-high (1 = reset)
//   halted        core halted; no new grant while high
//   if_req/if_addr                fetch request and address
//   if_rdata/if_ack               fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata     data request (d_we=1 store)
//   d_rdata/d_ack                 load data and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   busy          high whenever the arbiter is not IDLE
//   conflict_cnt  saturating count of grants made under contention
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             halted,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic [31:0]      if_rdata,
  output logic             if_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  output logic [31:0]      d_rdata,
  output logic             d_ack,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  // Owner / last-owner encoding: 0 = fetch, 1 = data.
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]   conflict_q, conflict_d;
  logic               pick_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q    <= IDLE;
      owner_q    <= OWN_FETCH;
      last_q     <= OWN_FETCH;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    conflict_d = conflict_q;
    // Data wins a tie only if fetch owned the previous grant.
    pick_data  = d_req && (!if_req || (last_q == OWN_FETCH));

    case (state_q)
      IDLE: begin
        if (!halted && (if_req || d_req)) begin
          owner_d = pick_data;
          last_d  = pick_data;
          we_d    = pick_data & d_we;
          addr_d  = pick_data ? d_addr : if_addr;
          wdata_d = pick_data ? d_wdata : wdata_q;
          cnt_d   = LAT_W'(MEM_LAT - 1);
          if (if_req && d_req) conflict_d = sat_inc(conflict_q);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_FETCH)  if_rdata_d = mem_rdata;
          else if (!we_q)            d_rdata_d  = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port strobes decode straight from the state register so they drop the
  // moment reset is asserted.
  assign mem_en       = (state_q == ACCESS);
  assign mem_we       = (state_q == ACCESS) && we_q && (owner_q == OWN_DATA);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign if_ack       = (state_q == DONE) && (owner_q == OWN_FETCH);
  assign d_ack        = (state_q == DONE) && (owner_q == OWN_DATA);
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign busy         = (state_q != IDLE);
  assign conflict_cnt = conflict_q;

endmodule
